// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard controller.
// Forward select encodings, FSM state enum, stall/flush bundle, MUL_LAT bounds.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam int MUL_LAT_MIN = 1;
  localparam int MUL_LAT_MAX = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic flush_w;
  } hz_ctl_t;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// fwd_sel: operand bypass select for one E-stage source register.
// In: rs, rd_m/we_m, rd_w/we_w. Out: sel (FWD_M beats FWD_W, x0 never forwarded).
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              we_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              we_w,
  output logic [1:0]        sel
);

  logic rs_nz;

  assign rs_nz = (rs != '0);

  always_comb begin
    sel = FWD_RF;
    if (rs_nz && we_m && (rs == rd_m)) begin
      sel = FWD_M;
    end else if (rs_nz && we_w && (rs == rd_w)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use, branch flush, MUL/DIV occupancy and
// dmem wait handling for the 5-stage RV32 pipe; drives per-stage stall/flush.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1D,
  input  logic [REG_AW-1:0] rs2D,
  input  logic [REG_AW-1:0] rs1E,
  input  logic [REG_AW-1:0] rs2E,
  input  logic [REG_AW-1:0] rdE,
  input  logic [REG_AW-1:0] rdM,
  input  logic [REG_AW-1:0] rdW,
  input  logic              reg_writeM,
  input  logic              reg_writeW,
  input  logic              mem_to_regE,
  input  logic              mul_startE,
  input  logic              branch_takenE,
  input  logic              dmem_reqM,
  input  logic              dmem_readyM,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam bit MUL_EN = (MUL_LAT > 1);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       mem_stall;
  logic       lu_haz;
  logic       mul_stall;
  logic [1:0] fwd_a, fwd_b;
  hz_ctl_t    ctl;

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs   (rs1E),
    .rd_m (rdM),
    .we_m (reg_writeM),
    .rd_w (rdW),
    .we_w (reg_writeW),
    .sel  (fwd_a)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs   (rs2E),
    .rd_m (rdM),
    .we_m (reg_writeM),
    .rd_w (rdW),
    .we_w (reg_writeW),
    .sel  (fwd_b)
  );

  assign mem_stall = dmem_reqM & ~dmem_readyM;
  assign lu_haz = mem_to_regE & (rdE != '0) &
                  ((rs1D == rdE) | (rs2D == rdE));

  // Occupancy tracking; a dmem wait freezes the counter so each wait
  // cycle stretches the multi-cycle window by one.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mul_stall = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MUL_EN && mul_startE && !mem_stall) begin
          mul_stall = 1'b1;
          state_d   = BUSY;
          cnt_d     = CNT_INIT;
        end
      end
      BUSY: begin
        mul_stall = (cnt_q != '0);
        if (!mem_stall) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strict priority; a pending dmem wait holds the whole pipe and lets
  // a branch in E resolve again once M completes.
  always_comb begin
    ctl = '0;
    if (rst) begin
      ctl = '0;
    end else if (mem_stall) begin
      ctl.stall_f = 1'b1;
      ctl.stall_d = 1'b1;
      ctl.stall_e = 1'b1;
      ctl.stall_m = 1'b1;
      ctl.flush_w = 1'b1;
    end else if (mul_stall) begin
      ctl.stall_f = 1'b1;
      ctl.stall_d = 1'b1;
      ctl.stall_e = 1'b1;
      ctl.flush_m = 1'b1;
    end else if (branch_takenE) begin
      ctl.flush_d = 1'b1;
      ctl.flush_e = 1'b1;
    end else if (lu_haz) begin
      ctl.stall_f = 1'b1;
      ctl.stall_d = 1'b1;
      ctl.flush_e = 1'b1;
    end
  end

  assign forwardAE = rst ? FWD_RF : fwd_a;
  assign forwardBE = rst ? FWD_RF : fwd_b;

  assign stallF = ctl.stall_f;
  assign stallD = ctl.stall_d;
  assign stallE = ctl.stall_e;
  assign stallM = ctl.stall_m;
  assign flushD = ctl.flush_d;
  assign flushE = ctl.flush_e;
  assign flushM = ctl.flush_m;
  assign flushW = ctl.flush_w;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl with MUL_LAT=4 and MUL_LAT=1.
// Control vector order: {stallF,stallD,stallE,stallM,flushD,flushE,flushM,flushW}.
module tb_hazard_ctrl;

  localparam logic [7:0] C_NONE = 8'h00;
  localparam logic [7:0] C_MEM  = 8'hF1;
  localparam logic [7:0] C_MUL  = 8'hE2;
  localparam logic [7:0] C_BR   = 8'h0C;
  localparam logic [7:0] C_LU   = 8'hC4;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic reg_writeM, reg_writeW, mem_to_regE, mul_startE;
  logic branch_takenE, dmem_reqM, dmem_readyM;

  logic [1:0] fa, fb, fa1, fb1;
  logic sF, sD, sE, sM, fD, fE, fM, fW;
  logic sF1, sD1, sE1, sM1, fD1, fE1, fM1, fW1;
  logic [7:0] ctl, ctl1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign ctl  = {sF, sD, sE, sM, fD, fE, fM, fW};
  assign ctl1 = {sF1, sD1, sE1, sM1, fD1, fE1, fM1, fW1};

  hazard_ctrl #(.REG_AW(5), .MUL_LAT(4)) dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW),
    .reg_writeM(reg_writeM), .reg_writeW(reg_writeW),
    .mem_to_regE(mem_to_regE), .mul_startE(mul_startE),
    .branch_takenE(branch_takenE),
    .dmem_reqM(dmem_reqM), .dmem_readyM(dmem_readyM),
    .forwardAE(fa), .forwardBE(fb),
    .stallF(sF), .stallD(sD), .stallE(sE), .stallM(sM),
    .flushD(fD), .flushE(fE), .flushM(fM), .flushW(fW)
  );

  hazard_ctrl #(.REG_AW(5), .MUL_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW),
    .reg_writeM(reg_writeM), .reg_writeW(reg_writeW),
    .mem_to_regE(mem_to_regE), .mul_startE(mul_startE),
    .branch_takenE(branch_takenE),
    .dmem_reqM(dmem_reqM), .dmem_readyM(dmem_readyM),
    .forwardAE(fa1), .forwardBE(fb1),
    .stallF(sF1), .stallD(sD1), .stallE(sE1), .stallM(sM1),
    .flushD(fD1), .flushE(fE1), .flushM(fM1), .flushW(fW1)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0;
    rdE = 0; rdM = 0; rdW = 0;
    reg_writeM = 0; reg_writeW = 0;
    mem_to_regE = 0; mul_startE = 0; branch_takenE = 0;
    dmem_reqM = 0; dmem_readyM = 1;
  endtask

  initial begin
    clr();
    rst = 1'b1;
    mul_startE = 1; rs1E = 5; rdM = 5; reg_writeM = 1;
    #1;
    chk("reset_ctl", ctl, C_NONE);
    chk("reset_fwdA", {6'd0, fa}, 8'h00);
    tick();
    tick();
    clr();
    rst = 1'b0;
    #1;
    chk("idle_ctl", ctl, C_NONE);

    // forwarding
    rs1E = 5; rdM = 5; reg_writeM = 1; rdW = 5; reg_writeW = 1;
    #1;
    chk("fwdA_M_over_W", {6'd0, fa}, 8'h02);
    chk("fwdB_x0", {6'd0, fb}, 8'h00);
    rs1E = 0; rdM = 0; rs2E = 7; rdW = 7;
    #1;
    chk("fwdA_x0", {6'd0, fa}, 8'h00);
    chk("fwdB_W", {6'd0, fb}, 8'h01);
    rs1E = 9; rdM = 4; rdW = 9; reg_writeW = 0;
    #1;
    chk("fwdA_W_disabled", {6'd0, fa}, 8'h00);
    rdM = 9; reg_writeM = 1;
    #1;
    chk("fwdA_M", {6'd0, fa}, 8'h02);
    chk("fwd_no_side_ctl", ctl, C_NONE);
    clr();

    // load-use
    tick();
    mem_to_regE = 1; rdE = 3; rs2D = 3;
    #1;
    chk("lu_stall", ctl, C_LU);
    tick();
    mem_to_regE = 0; rdE = 0; rdM = 3; reg_writeM = 1;
    #1;
    chk("lu_one_bubble", ctl, C_NONE);
    clr();
    mem_to_regE = 1; rdE = 0; rs1D = 0;
    #1;
    chk("lu_x0_no_stall", ctl, C_NONE);
    clr();

    // multi-cycle op, MUL_LAT=4 vs 1
    tick();
    mul_startE = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("mul_c%0d", i), ctl, (i < 3) ? C_MUL : C_NONE);
      chk($sformatf("mul1_c%0d", i), ctl1, C_NONE);
      tick();
    end
    mul_startE = 0;
    #1;
    chk("mul_done", ctl, C_NONE);

    // multi-cycle op with a 2-cycle dmem wait mid-BUSY
    tick();
    mul_startE = 1;
    for (int i = 0; i < 6; i++) begin
      dmem_reqM   = (i == 1 || i == 2);
      dmem_readyM = !(i == 1 || i == 2);
      #1;
      case (i)
        1, 2:    chk($sformatf("mulw_c%0d", i), ctl, C_MEM);
        0, 3, 4: chk($sformatf("mulw_c%0d", i), ctl, C_MUL);
        default: chk($sformatf("mulw_c%0d", i), ctl, C_NONE);
      endcase
      chk($sformatf("mulw1_c%0d", i), ctl1,
          (i == 1 || i == 2) ? C_MEM : C_NONE);
      tick();
    end
    clr();
    tick();

    // branch priority
    mem_to_regE = 1; rdE = 3; rs1D = 3; branch_takenE = 1;
    #1;
    chk("br_over_lu", ctl, C_BR);
    dmem_reqM = 1; dmem_readyM = 0;
    #1;
    chk("mem_over_br", ctl, C_MEM);
    clr();
    tick();

    // async reset in BUSY with cnt=1
    mul_startE = 1;
    rs1E = 5; rdM = 5; reg_writeM = 1;
    #1;
    chk("rb_c0", ctl, C_MUL);
    tick();
    tick();
    chk("rb_c2", ctl, C_MUL);
    #1;
    rst = 1'b1;
    #1;
    chk("rb_async_ctl", ctl, C_NONE);
    chk("rb_async_fwd", {6'd0, fa}, 8'h00);
    tick();
    rst = 1'b0;
    mul_startE = 0;
    #1;
    chk("rb_after_ctl", ctl, C_NONE);
    chk("rb_after_fwd", {6'd0, fa}, 8'h02);
    tick();
    mul_startE = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rb_idle_c%0d", i), ctl, (i < 3) ? C_MUL : C_NONE);
      tick();
    end
    clr();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage RV32 core. It sits beside the datapath and resolves data hazards (M/W forwarding with x0 exclusion, load-use stall), control hazards (taken-branch flush from E), and structural hazards that need state: a multi-cycle execute unit (MUL/DIV) tracked by an internal occupancy counter, and a data-memory ready/valid wait in M. It drives per-stage stall and flush enables for the F/D, D/E, E/M and M/W pipeline registers.

## Interface
- REG_AW, 5: register-address width.
- MUL_LAT, 4: cycles a multi-cycle op occupies E; legal range 1..16; 1 disables the FSM.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs1D, rs2D  in  REG_AW  source registers in D.
- rs1E, rs2E, rdE  in  REG_AW  sources and destination in E.
- rdM, rdW  in  REG_AW  destinations in M and W.
- reg_writeM, reg_writeW  in  1  destination write enables.
- mem_to_regE  in  1  E holds a load.
- mul_startE  in  1  E holds a multi-cycle op; held high while stalled.
- branch_takenE  in  1  branch/jump in E resolved taken.
- dmem_reqM, dmem_readyM  in  1  M memory access request / completion.
- forwardAE, forwardBE  out  2  operand source: 00 RF, 01 W, 10 M.
- stallF, stallD, stallE, stallM  out  1  hold pipeline register.
- flushD, flushE, flushM, flushW  out  1  insert bubble into register.

## Operation
- Forwarding, per operand: rsXE!=0 & rsXE==rdM & reg_writeM -> 10; else rsXE!=0 & rsXE==rdW & reg_writeW -> 01; else 00. M wins over W.
- lu_haz = mem_to_regE & rdE!=0 & (rs1D==rdE | rs2D==rdE). x0 destination never stalls.
- mem_stall = dmem_reqM & !dmem_readyM.
- FSM states IDLE, BUSY; counter cnt, width clog2(MUL_LAT) (min 1).
  - IDLE & mul_startE & MUL_LAT>1 & !mem_stall: mul_stall=1; next BUSY, cnt<=MUL_LAT-2.
  - BUSY: mul_stall = (cnt!=0). If mem_stall: state and cnt frozen. Else cnt==0 -> IDLE; else cnt<=cnt-1.
  - mul_startE ignored in BUSY.
- Output priority, highest first (only one row active):
  - mem_stall: stallF/D/E/M=1, flushW=1; all other flushes 0 (branch in E re-evaluated later).
  - mul_stall: stallF/D/E=1, flushM=1.
  - branch_takenE: flushD=1, flushE=1, no stalls (overrides lu_haz; the D instruction is squashed).
  - lu_haz: stallF=1, stallD=1, flushE=1.
  - none: all stall/flush 0.
- Forward selects are independent of the priority rows.
- branch_takenE and mul_startE are never both high (single E instruction); behaviour then unspecified.

## Timing
- All outputs combinational from inputs and FSM state; zero-cycle latency.
- While rst high: state IDLE, cnt 0, every output 0. Reset mid-BUSY returns to IDLE immediately; stalls drop in the same cycle.
- Multi-cycle op entering E at cycle t (MUL_LAT=N>1): stalls asserted t..t+N-2, released at t+N-1; the op leaves E at the t+N-1 edge. N=2 gives exactly one stall cycle.
- Each mem_stall cycle during BUSY extends the stall window by one cycle.
- Load-use: exactly one bubble per hazard. The load reaches M next cycle, lu_haz clears, and forwarding covers the dependency from W one cycle later.

## Structure
- Package hazard_pkg: forward encodings FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10; FSM state enum; MUL_LAT bounds.
- One natural sub-module: fwd_sel (operand address + M/W destinations/enables -> 2-bit select), instantiated twice.
- FSM, counter and priority logic live in hazard_ctrl.

## Test plan
- rs1E=5, rdM=5, reg_writeM=1, rdW=5, reg_writeW=1 -> forwardAE=10. rdM=0 case with rs1E=0 -> 00. rs2E=7=rdW only -> forwardBE=01.
- mem_to_regE=1, rdE=3, rs2D=3 -> stallF=stallD=flushE=1 for one cycle. Same with rdE=0 -> no stall.
- MUL_LAT=4, mul_startE pulse held -> stallF/D/E and flushM high exactly 3 cycles, then low; MUL_LAT=1 -> never stalls.
- MUL_LAT=4 with dmem_readyM=0 for 2 cycles mid-BUSY -> stall window 5 cycles; stallM and flushW high only in the wait cycles.
- branch_takenE=1 with lu_haz true -> flushD=flushE=1, stallF=stallD=0; with mem_stall also true -> only stalls and flushW.
- Assert rst asynchronously in BUSY cnt=1 -> all outputs 0 immediately; after release with mul_startE=0 -> state IDLE, no stall.
